// File: rtl/voice_allocator.sv
// Polyphony controller: shares NUM_VOICES tone voices among NUM_KEYS keys.
// It scans one key per cycle, allocates or frees voices, and steals the oldest voice.
// Ports:
//   clk          system clock
//   reset        async active-high reset
//   KEYBOARD     debounced key levels, 1 = pressed
//   scale        current scale, latched per voice at allocation
//   voice_active 1 = voice is sounding
//   voice_key    key index per voice, voice v at [v*KW +: KW]
//   voice_scale  latched scale per voice, voice v at [v*3 +: 3]
//   steal        one-cycle pulse when an active voice is reassigned
module voice_allocator #(
    parameter int NUM_KEYS   = 13,
    parameter int NUM_VOICES = 4,
    parameter int AGE_W      = 4
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [NUM_KEYS-1:0]                        KEYBOARD,
    input  logic [2:0]                                 scale,
    output logic [NUM_VOICES-1:0]                      voice_active,
    output logic [NUM_VOICES*$clog2(NUM_KEYS)-1:0]     voice_key,
    output logic [NUM_VOICES*3-1:0]                    voice_scale,
    output logic                                       steal
);

    localparam int KW = $clog2(NUM_KEYS);
    localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};
    localparam logic [KW-1:0] LAST_KEY = KW'(NUM_KEYS - 1);

    logic [KW-1:0]       scan_ptr;
    logic [NUM_KEYS-1:0] assigned;
    logic [NUM_KEYS-1:0] suppressed;
    logic [AGE_W-1:0]    age [NUM_VOICES];

    logic [VW-1:0]    hit_v;
    logic [VW-1:0]    free_v;
    logic [VW-1:0]    vic_v;
    logic [VW-1:0]    sel_v;
    logic [AGE_W-1:0] vic_age;
    logic [KW-1:0]    old_key;
    logic             free_ok;
    logic             key_down;
    logic             do_rel;
    logic             do_unsup;
    logic             do_alloc;

    always_comb begin
        hit_v   = '0;
        free_v  = '0;
        free_ok = 1'b0;
        vic_v   = '0;
        vic_age = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (voice_active[v] && voice_key[v*KW +: KW] == scan_ptr)
                hit_v = VW'(v);
            if (!voice_active[v] && !free_ok) begin
                free_ok = 1'b1;
                free_v  = VW'(v);
            end
            // Strict compare keeps the lowest index on equal ages.
            if (age[v] > vic_age) begin
                vic_age = age[v];
                vic_v   = VW'(v);
            end
        end
        sel_v    = free_ok ? free_v : vic_v;
        old_key  = voice_key[sel_v*KW +: KW];
        key_down = KEYBOARD[scan_ptr];
        do_rel   = !key_down && assigned[scan_ptr];
        do_unsup = !key_down && suppressed[scan_ptr];
        do_alloc = key_down && !assigned[scan_ptr] && !suppressed[scan_ptr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scan_ptr     <= '0;
            assigned     <= '0;
            suppressed   <= '0;
            voice_active <= '0;
            voice_key    <= '0;
            voice_scale  <= '0;
            steal        <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++)
                age[v] <= '0;
        end else begin
            steal    <= 1'b0;
            scan_ptr <= (scan_ptr == LAST_KEY) ? '0 : scan_ptr + 1'b1;
            if (do_rel) begin
                voice_active[hit_v] <= 1'b0;
                assigned[scan_ptr]  <= 1'b0;
            end else if (do_unsup) begin
                suppressed[scan_ptr] <= 1'b0;
            end else if (do_alloc) begin
                // Stolen key must be released and re-pressed before it sounds again.
                if (!free_ok) begin
                    assigned[old_key]   <= 1'b0;
                    suppressed[old_key] <= 1'b1;
                    steal               <= 1'b1;
                end
                assigned[scan_ptr]            <= 1'b1;
                voice_active[sel_v]           <= 1'b1;
                voice_key[sel_v*KW +: KW]     <= scan_ptr;
                voice_scale[sel_v*3 +: 3]     <= scale;
                for (int v = 0; v < NUM_VOICES; v++) begin
                    if (VW'(v) == sel_v)
                        age[v] <= '0;
                    else if (voice_active[v] && age[v] != AGE_MAX)
                        age[v] <= age[v] + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator: behavioural model plus directed checks.
// Drives inputs on the falling edge and compares outputs on the falling edge.
module tb_voice_allocator;

    localparam int NK = 13;
    localparam int NV = 4;
    localparam int KW = 4;
    localparam int AMAX = 15;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NK-1:0]     KEYBOARD = '0;
    logic [2:0]        scale = '0;
    logic [NV-1:0]     voice_active;
    logic [NV*KW-1:0]  voice_key;
    logic [NV*3-1:0]   voice_scale;
    logic              steal;

    int n_cmp = 0;
    int n_bad = 0;
    int steal_cnt = 0;

    // Model state
    int m_key [NV];
    int m_scale [NV];
    int m_age [NV];
    bit m_act [NV];
    bit m_sup [NK];
    int m_ptr;
    bit m_steal;

    voice_allocator dut (
        .clk(clk),
        .reset(reset),
        .KEYBOARD(KEYBOARD),
        .scale(scale),
        .voice_active(voice_active),
        .voice_key(voice_key),
        .voice_scale(voice_scale),
        .steal(steal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic m_reset();
        for (int v = 0; v < NV; v++) begin
            m_key[v] = 0; m_scale[v] = 0; m_age[v] = 0; m_act[v] = 0;
        end
        for (int k = 0; k < NK; k++) m_sup[k] = 0;
        m_ptr = 0;
        m_steal = 0;
    endtask

    task automatic m_step();
        int k, owner, tgt;
        k = m_ptr;
        owner = -1;
        tgt = -1;
        m_steal = 0;
        for (int v = 0; v < NV; v++)
            if (m_act[v] && m_key[v] == k) owner = v;
        if (!KEYBOARD[k] && owner >= 0) begin
            m_act[owner] = 0;
        end else if (!KEYBOARD[k] && m_sup[k]) begin
            m_sup[k] = 0;
        end else if (KEYBOARD[k] && owner < 0 && !m_sup[k]) begin
            for (int v = NV - 1; v >= 0; v--)
                if (!m_act[v]) tgt = v;
            if (tgt < 0) begin
                tgt = 0;
                for (int v = 1; v < NV; v++)
                    if (m_age[v] > m_age[tgt]) tgt = v;
                m_sup[m_key[tgt]] = 1;
                m_steal = 1;
            end
            for (int v = 0; v < NV; v++)
                if (v != tgt && m_act[v] && m_age[v] < AMAX) m_age[v]++;
            m_key[tgt] = k;
            m_scale[tgt] = int'(scale);
            m_act[tgt] = 1;
            m_age[tgt] = 0;
        end
        m_ptr = (k + 1) % NK;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) m_reset();
            else m_step();
        end
    end

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            logic [NV-1:0]    ea;
            logic [NV*KW-1:0] ek;
            logic [NV*3-1:0]  es;
            for (int v = 0; v < NV; v++) begin
                ea[v] = m_act[v];
                ek[v*KW +: KW] = KW'(m_key[v]);
                es[v*3 +: 3] = 3'(m_scale[v]);
            end
            check("model_active", 64'(voice_active), 64'(ea));
            check("model_key", 64'(voice_key), 64'(ek));
            check("model_scale", 64'(voice_scale), 64'(es));
            check("model_steal", 64'(steal), 64'(m_steal));
            if (steal) steal_cnt++;
        end
    end

    task automatic wait_active(input logic [NV-1:0] req, input int budget,
                               input string name);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (voice_active == req) break;
        end
        check(name, 64'(voice_active), 64'(req));
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        cycles(3);
        check("rst_active", 64'(voice_active), 64'h0);
        check("rst_key", 64'(voice_key), 64'h0);
        check("rst_scale", 64'(voice_scale), 64'h0);
        check("rst_steal", 64'(steal), 64'h0);
        reset = 1'b0;

        // Single note
        scale = 3'd2;
        KEYBOARD[5] = 1'b1;
        wait_active(4'b0001, 14, "single_on");
        check("single_key", 64'(voice_key[3:0]), 64'd5);
        check("single_scale", 64'(voice_scale[2:0]), 64'd2);
        KEYBOARD[5] = 1'b0;
        wait_active(4'b0000, 14, "single_off");

        // Fill all four voices
        scale = 3'd0;
        steal_cnt = 0;
        KEYBOARD[1] = 1'b1;
        wait_active(4'b0001, 14, "fill_1");
        KEYBOARD[3] = 1'b1;
        wait_active(4'b0011, 14, "fill_3");
        KEYBOARD[7] = 1'b1;
        wait_active(4'b0111, 14, "fill_7");
        KEYBOARD[9] = 1'b1;
        wait_active(4'b1111, 14, "fill_9");
        check("fill_keys", 64'(voice_key), 64'h9731);
        check("fill_nosteal", 64'(steal_cnt), 64'd0);

        // Steal oldest (voice 0, key 1)
        KEYBOARD[11] = 1'b1;
        cycles(14);
        check("steal_keys", 64'(voice_key), 64'h973B);
        check("steal_pulses", 64'(steal_cnt), 64'd1);
        cycles(26);
        check("suppressed_held", 64'(voice_key), 64'h973B);
        check("suppressed_nosteal", 64'(steal_cnt), 64'd1);

        // Re-press key 1 after a full released scan: steals voice 1 (key 3)
        KEYBOARD[1] = 1'b0;
        cycles(14);
        KEYBOARD[1] = 1'b1;
        cycles(14);
        check("repress_keys", 64'(voice_key), 64'h971B);
        check("repress_pulses", 64'(steal_cnt), 64'd2);

        // Scale latch
        KEYBOARD = '0;
        wait_active(4'b0000, 14, "all_off");
        scale = 3'd1;
        KEYBOARD[2] = 1'b1;
        wait_active(4'b0001, 14, "latch_on");
        check("latch_key", 64'(voice_key[3:0]), 64'd2);
        scale = 3'd4;
        cycles(14);
        check("latch_hold", 64'(voice_scale[2:0]), 64'd1);
        KEYBOARD[4] = 1'b1;
        wait_active(4'b0011, 14, "latch_second");
        check("latch_new_key", 64'(voice_key[7:4]), 64'd4);
        check("latch_new_scale", 64'(voice_scale[5:3]), 64'd4);

        // Async reset mid-scan with three voices active
        KEYBOARD[6] = 1'b1;
        wait_active(4'b0111, 14, "three_on");
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("async_active", 64'(voice_active), 64'h0);
        check("async_steal", 64'(steal), 64'h0);
        KEYBOARD = '0;
        KEYBOARD[0] = 1'b1;
        KEYBOARD[12] = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("first_slot_active", 64'(voice_active), 64'h1);
        check("first_slot_key", 64'(voice_key[3:0]), 64'd0);
        wait_active(4'b0011, 14, "last_slot");
        check("last_slot_key", 64'(voice_key[7:4]), 64'd12);
        KEYBOARD = '0;
        wait_active(4'b0000, 14, "final_off");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
